// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// registered three-way compare result.
package seq_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_result_t;

   localparam cmp_result_t RESULT_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

   // Less-than is implied once greater and equal are both known to be false.
   function automatic cmp_result_t makeResult(input logic gt, input logic eq);
      return '{gt: gt, eq: eq, lt: !gt && !eq};
   endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit slice; the caller derives
// less-than from the two outputs.
module digit_comparator #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq
);

   assign o_gt = (i_a > i_b);
   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first one slice per
// clock and stops at the first differing slice.
module seq_magnitude_comparator
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [WIDTH-1:0]                  a,
   input  logic [WIDTH-1:0]                  b,
   input  logic                              is_signed,
   output logic                              busy,
   output logic                              done,
   output logic                              is_greater,
   output logic                              is_equal,
   output logic                              is_less,
   output logic [$clog2(WIDTH/DIGIT+1)-1:0]  digits_used
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

   state_t              r_state;
   state_t              w_next;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_digits;
   cmp_result_t         r_result;

   logic [DIGIT-1:0]    w_sliceA;
   logic [DIGIT-1:0]    w_sliceB;
   logic                w_gt;
   logic                w_eq;
   logic                w_accept;
   logic                w_finish;

   // A new request is taken in IDLE or straight out of DONE for back-to-back use.
   assign w_accept = start && (r_state != COMPARE);
   assign w_finish = (r_state == COMPARE) && (!w_eq || (r_idx == '0));

   always_comb begin
      w_sliceA = r_a[int'(r_idx) * DIGIT +: DIGIT];
      w_sliceB = r_b[int'(r_idx) * DIGIT +: DIGIT];
   end

   digit_comparator #(
      .DIGIT (DIGIT)
   ) u_digit_cmp (
      .i_a  (w_sliceA),
      .i_b  (w_sliceB),
      .o_gt (w_gt),
      .o_eq (w_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next = COMPARE;
            end
         end
         COMPARE: begin
            if (w_finish) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = start ? COMPARE : IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Flipping the sign bit of both operands maps two's-complement order onto
   // unsigned order, so the slice scan itself never needs to know the mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_count  <= '0;
         r_digits <= '0;
         r_result <= RESULT_NONE;
      end else if (w_accept) begin
         r_a     <= a ^ (is_signed ? SIGN_BIT : '0);
         r_b     <= b ^ (is_signed ? SIGN_BIT : '0);
         r_idx   <= IDX_W'(NUM_DIGITS - 1);
         r_count <= '0;
      end else if (r_state == COMPARE) begin
         r_count <= r_count + CNT_W'(1);
         if (w_finish) begin
            r_result <= makeResult(w_gt, w_eq);
            r_digits <= r_count + CNT_W'(1);
         end else begin
            r_idx <= r_idx - IDX_W'(1);
         end
      end
   end

   assign busy        = (r_state == COMPARE);
   assign done        = (r_state == DONE);
   assign is_greater  = r_result.gt;
   assign is_equal    = r_result.eq;
   assign is_less     = r_result.lt;
   assign digits_used = r_digits;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator at WIDTH=16, DIGIT=2; every
// expected value below is worked out by hand from the operand slices.
module tb_seq_magnitude_comparator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        done;
   logic        is_greater;
   logic        is_equal;
   logic        is_less;
   logic [3:0]  digits_used;

   int nChecks = 0;
   int nFails  = 0;
   int cyc;
   bit seen;

   always #5 clk = ~clk;

   seq_magnitude_comparator #(
      .WIDTH (16),
      .DIGIT (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .is_signed   (is_signed),
      .busy        (busy),
      .done        (done),
      .is_greater  (is_greater),
      .is_equal    (is_equal),
      .is_less     (is_less),
      .digits_used (digits_used)
   );

   // Drive a request for one cycle, then scramble the inputs so any late
   // sampling of operands or mode would show up in the result.
   task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB, input logic sgn);
      @(posedge clk); #1;
      a = opA; b = opB; is_signed = sgn; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~opA; b = ~opB; is_signed = ~sgn;
   endtask

   // Called just after an edge that begins cycle firstCyc; returns the cycle
   // in which done was seen, with a bounded wait.
   task automatic waitDone(input int firstCyc, output int cycOut, output bit seenOut);
      cycOut = firstCyc;
      seenOut = 1'b0;
      for (int i = 0; i < 40 && !seenOut; i++) begin
         @(negedge clk);
         if (done) seenOut = 1'b1;
         else cycOut++;
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_flags: got %b expected 000", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd0) begin nFails++; $display("[TB] FAIL reset_digits: got %0d expected 0", digits_used); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned_greater;
      applyStimulus(16'hC000, 16'h4000, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if (seen !== 1'b1) begin nFails++; $display("[TB] FAIL ugt_done_seen: got %b expected 1", seen); end
      nChecks++; if (cyc != 2) begin nFails++; $display("[TB] FAIL ugt_latency: got cycle %0d expected 2", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b100) begin nFails++; $display("[TB] FAIL ugt_flags: got %b expected 100", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd1) begin nFails++; $display("[TB] FAIL ugt_digits: got %0d expected 1", digits_used); end
   endtask

   task automatic test_equal;
      applyStimulus(16'h1234, 16'h1234, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if (seen !== 1'b1) begin nFails++; $display("[TB] FAIL eq_done_seen: got %b expected 1", seen); end
      nChecks++; if (cyc != 9) begin nFails++; $display("[TB] FAIL eq_latency: got cycle %0d expected 9", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b010) begin nFails++; $display("[TB] FAIL eq_flags: got %b expected 010", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd8) begin nFails++; $display("[TB] FAIL eq_digits: got %0d expected 8", digits_used); end
      @(negedge clk);
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL eq_done_pulse_width: got %b expected 0", done); end
   endtask

   task automatic test_signed;
      applyStimulus(16'hFFFF, 16'h0001, 1'b1);
      waitDone(1, cyc, seen);
      nChecks++; if (cyc != 2) begin nFails++; $display("[TB] FAIL signed_latency: got cycle %0d expected 2", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b001) begin nFails++; $display("[TB] FAIL signed_flags: got %b expected 001", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd1) begin nFails++; $display("[TB] FAIL signed_digits: got %0d expected 1", digits_used); end
      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if (cyc != 2) begin nFails++; $display("[TB] FAIL unsigned_rerun_latency: got cycle %0d expected 2", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b100) begin nFails++; $display("[TB] FAIL unsigned_rerun_flags: got %b expected 100", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd1) begin nFails++; $display("[TB] FAIL unsigned_rerun_digits: got %0d expected 1", digits_used); end
   endtask

   task automatic test_lsb_difference;
      applyStimulus(16'h0003, 16'h0002, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if (cyc != 9) begin nFails++; $display("[TB] FAIL lsb_latency: got cycle %0d expected 9", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b100) begin nFails++; $display("[TB] FAIL lsb_flags: got %b expected 100", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd8) begin nFails++; $display("[TB] FAIL lsb_digits: got %0d expected 8", digits_used); end
   endtask

   task automatic test_ignored_start;
      applyStimulus(16'h0001, 16'h0002, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL ign_busy: got %b expected 1", busy); end
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(4, cyc, seen);
      nChecks++; if (cyc != 9) begin nFails++; $display("[TB] FAIL ign_latency: got cycle %0d expected 9", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b001) begin nFails++; $display("[TB] FAIL ign_flags: got %b expected 001", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd8) begin nFails++; $display("[TB] FAIL ign_digits: got %0d expected 8", digits_used); end
      @(negedge clk);
      @(negedge clk);
      nChecks++; if ({busy, done} !== 2'b00) begin nFails++; $display("[TB] FAIL ign_no_second_run: got busy/done %b expected 00", {busy, done}); end
   endtask

   task automatic test_back_to_back;
      applyStimulus(16'h0001, 16'h0002, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b001) begin nFails++; $display("[TB] FAIL b2b_first_flags: got %b expected 001", {is_greater, is_equal, is_less}); end
      a = 16'h8000; b = 16'h8000; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 16'h0000; b = 16'h0001;
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_accepted: got busy %b expected 1", busy); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b001) begin nFails++; $display("[TB] FAIL b2b_flags_held: got %b expected 001", {is_greater, is_equal, is_less}); end
      waitDone(1, cyc, seen);
      nChecks++; if (cyc != 9) begin nFails++; $display("[TB] FAIL b2b_latency: got cycle %0d expected 9", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b010) begin nFails++; $display("[TB] FAIL b2b_second_flags: got %b expected 010", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd8) begin nFails++; $display("[TB] FAIL b2b_digits: got %0d expected 8", digits_used); end
   endtask

   task automatic test_reset_abort;
      applyStimulus(16'h1234, 16'h1234, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      nChecks++; if ({busy, done} !== 2'b00) begin nFails++; $display("[TB] FAIL abort_busy_done: got %b expected 00", {busy, done}); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b000) begin nFails++; $display("[TB] FAIL abort_flags: got %b expected 000", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd0) begin nFails++; $display("[TB] FAIL abort_digits: got %0d expected 0", digits_used); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      nChecks++; if (seen !== 1'b0) begin nFails++; $display("[TB] FAIL abort_no_done: got activity %b expected 0", seen); end
      applyStimulus(16'hC000, 16'h4000, 1'b0);
      waitDone(1, cyc, seen);
      nChecks++; if (cyc != 2) begin nFails++; $display("[TB] FAIL abort_restart_latency: got cycle %0d expected 2", cyc); end
      nChecks++; if ({is_greater, is_equal, is_less} !== 3'b100) begin nFails++; $display("[TB] FAIL abort_restart_flags: got %b expected 100", {is_greater, is_equal, is_less}); end
      nChecks++; if (digits_used !== 4'd1) begin nFails++; $display("[TB] FAIL abort_restart_digits: got %0d expected 1", digits_used); end
   endtask

   initial begin
      $display("[TB] starting seq_magnitude_comparator bench");
      test_reset;
      test_unsigned_greater;
      test_equal;
      test_signed;
      test_lsb_difference;
      test_ignored_start;
      test_back_to_back;
      test_reset_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, signed or unsigned per request. Scans operands MSB-first one DIGIT-bit slice per clock and terminates early at the first differing slice. Produces registered greater/equal/less flags plus a count of slices examined. Sits behind a start/done handshake, so one small slice comparator serves arbitrarily wide operands.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, slice width compared per cycle; 1 <= DIGIT <= WIDTH.
- Derived (localparam) NUM_DIGITS = WIDTH/DIGIT; CNT_W = $clog2(NUM_DIGITS+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; sampled with an accepted start.
- b  in  WIDTH  operand B; sampled with an accepted start.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  out  1  high while a comparison is in progress.
- done  out  1  single-cycle pulse; result flags valid from this cycle.
- is_greater  out  1  a > b.
- is_equal  out  1  a == b.
- is_less  out  1  a < b.
- digits_used  out  CNT_W  number of slices examined, 1..NUM_DIGITS.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, is_greater, is_equal, is_less = 0; digits_used = 0; internal operand registers = 0. Takes effect immediately, including mid-comparison. An aborted comparison produces no done.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - busy=0.
  - start=1: latch a, b and is_signed; if signed, invert bit WIDTH-1 of both latched operands (bias trick; the unsigned compare then orders correctly).
  - Set idx = NUM_DIGITS-1 and count = 0; go to COMPARE.
- COMPARE:
  - busy=1.
  - Compare slice idx of A vs B (unsigned DIGIT-bit); count increments.
  - Slices differ: register gt/lt from that slice, eq=0; go to DONE.
  - Slices equal and idx==0: register eq=1, gt=lt=0; go to DONE.
  - Otherwise decrement idx and stay in COMPARE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Flags and digits_used update on the edge entering DONE.
  - Next state is IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back operation).
- Latency: with start accepted in cycle 0 and first difference at slice position k from the top (k=1..NUM_DIGITS), done is high in cycle k+1 and digits_used=k. Equal operands: done in cycle NUM_DIGITS+1.
- Result outputs hold their last value until the next done; they are not cleared on start.
- start while busy=1 is ignored. Operand and mode changes after acceptance have no effect.
- Exactly one of is_greater, is_equal, is_less is 1 after the first done; all are 0 before it.
- DIGIT=WIDTH degenerates to a fixed 2-cycle compare.

Decomposition:
- Package seq_cmp_pkg holds the FSM state enum (IDLE, COMPARE, DONE) and a cmp_result_t struct {gt, eq, lt}.
- One sub-module, digit_comparator: parametrised DIGIT-bit unsigned combinational gt/eq, instantiated once on the slice selected by idx.
- The top level owns the FSM, operand registers, slice mux and counter.

Test Plan:
All cases use WIDTH=16, DIGIT=2.
- Unsigned a=16'hC000, b=16'h4000, start in cycle 0 -> done in cycle 2, is_greater=1, digits_used=1.
- a=b=16'h1234 -> done in cycle 9, is_equal=1, digits_used=8.
- a=16'hFFFF, b=16'h0001: with is_signed=1 -> is_less=1, digits_used=1; rerun with is_signed=0 -> is_greater=1, digits_used=1.
- a=16'h0003, b=16'h0002 unsigned -> is_greater=1, digits_used=8, done in cycle 9.
- Handshake sequence:
  - Start (16'h0001 vs 16'h0002), then pulse start with 16'hFFFF vs 0 in cycle 3 -> ignored; first result is is_less=1.
  - start held high in the DONE cycle with 16'h8000 vs 16'h8000 -> accepted; next done shows is_equal=1.
- rst_n low for one cycle in cycle 4 of a compare -> busy, flags and digits_used drop to 0 immediately, no done pulse; a new start afterwards completes normally.
